// File: rtl/spi_master_param.sv
// spi_master_param: SPI master, all four modes, runtime SCK divider.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_master_param #(
   parameter int DATA_W   = 8,
   parameter int NUM_SS   = 1,
   parameter int SS_IDX_W = 1,
   parameter int DIV_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                cpol,
   input  logic                cpha,
   input  logic [DIV_W-1:0]    clk_div,
   input  logic [SS_IDX_W-1:0] ss_idx,
   input  logic [DATA_W-1:0]   tx_data,
   output logic [DATA_W-1:0]   rx_data,
   output logic                busy,
   output logic                done,
   output logic                sck,
   output logic                mosi,
   input  logic                miso,
   output logic [NUM_SS-1:0]   ss_n
);

   localparam int BCW = $clog2(2 * DATA_W) + 1;
   localparam logic [BCW-1:0] LAST_EDGE = BCW'(2 * DATA_W);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD
   } state_t;

   state_t            state;
   logic              cpol_q;
   logic              cpha_q;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_cnt;
   logic [BCW-1:0]    edge_cnt;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;

   logic [BCW-1:0]    next_edge;
   logic              do_sample;
   logic              do_shift;
   logic              half_end;

   function automatic logic [NUM_SS-1:0] ss_decode(
      input logic [SS_IDX_W-1:0] idx
   );
      logic [NUM_SS-1:0] v;
      v = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (32'(idx) == i) v[i] = 1'b0;
      return v;
   endfunction

`ifdef SPI_MASTER_LSB_FIRST_EN
   function automatic logic tx_bit(
      input logic [DATA_W-1:0] d
   );
      return d[0];
   endfunction

   function automatic logic [DATA_W-1:0] tx_adv(
      input logic [DATA_W-1:0] d
   );
      return d >> 1;
   endfunction

   function automatic logic [DATA_W-1:0] rx_ins(
      input logic [DATA_W-1:0] d,
      input logic              b
   );
      return {b, d[DATA_W-1:1]};
   endfunction
`else
   function automatic logic tx_bit(
      input logic [DATA_W-1:0] d
   );
      return d[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] tx_adv(
      input logic [DATA_W-1:0] d
   );
      return d << 1;
   endfunction

   function automatic logic [DATA_W-1:0] rx_ins(
      input logic [DATA_W-1:0] d,
      input logic              b
   );
      return {d[DATA_W-2:0], b};
   endfunction
`endif

   // Odd edges are leading edges; cpha picks which of the pair samples.
   always_comb begin
      next_edge = edge_cnt + 1'b1;
      do_sample = next_edge[0] ^ cpha_q;
      do_shift  = ~do_sample & (next_edge != LAST_EDGE);
      half_end  = (div_cnt == div_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         ss_n     <= '1;
         busy     <= 1'b0;
         done     <= 1'b0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         div_q    <= '0;
         div_cnt  <= '0;
         edge_cnt <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         // An aborted frame leaves the previous result visible.
         if (!busy) rx_data <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               sck  <= cpol;
               ss_n <= '1;
               busy <= 1'b0;
               if (start) begin
                  state    <= SETUP;
                  busy     <= 1'b1;
                  ss_n     <= ss_decode(ss_idx);
                  cpol_q   <= cpol;
                  cpha_q   <= cpha;
                  div_q    <= clk_div;
                  div_cnt  <= '0;
                  edge_cnt <= '0;
                  rx_sr    <= '0;
                  if (cpha) begin
                     tx_sr <= tx_data;
                     mosi  <= 1'b0;
                  end else begin
                     tx_sr <= tx_adv(tx_data);
                     mosi  <= tx_bit(tx_data);
                  end
               end
            end
            SETUP, XFER: begin
               if (!half_end) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (edge_cnt == LAST_EDGE) begin
                     state <= HOLD;
                  end else begin
                     state    <= XFER;
                     sck      <= ~sck;
                     edge_cnt <= next_edge;
                     if (do_sample)
                        rx_sr <= rx_ins(rx_sr, miso);
                     if (do_shift) begin
                        mosi  <= tx_bit(tx_sr);
                        tx_sr <= tx_adv(tx_sr);
                     end
                  end
               end
            end
            HOLD: begin
               if (!half_end) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  state   <= IDLE;
                  sck     <= cpol_q;
                  ss_n    <= '1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  rx_data <= rx_sr;
               end
            end
         endcase
      end
   end

endmodule
